pwm_ramp_ctrl: RTL and testbench

Command-driven sequencer that configures and drives one pwm instance. It accepts a ramp command (target duty, step size, hold time, period) through a valid/ready handshake. It walks the pwm duty_cycle input from its present value to the target in saturating steps, with one step every (hold+1) clocks. It signals completion or abort. It sits between a register/CPU interface and the pwm datapath, and owns that instance's duty_cycle and final_value inputs.

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_ramp_step.sv | 20 ++
 rtl/pwm_ramp_ctrl.sv | 103 ++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared ramp-controller state encoding and default pwm widths
package pwm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, DONE = 2'd2} ramp_state_t;
    localparam int R_DEF          = 8;
    localparam int TIMER_BITS_DEF = 15;
    localparam int HOLD_BITS_DEF  = 16;
endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: one saturating step of a duty value toward its target
module pwm_ramp_step #(
    parameter int R = 8
) (
    input  logic [R-1:0] duty,
    input  logic [R-1:0] target,
    input  logic [R-1:0] step,
    output logic [R-1:0] next_duty,
    output logic         reached
);
    logic         up;
    logic [R-1:0] diff;
    // step only while it stays short of the target, so no overshoot or wrap
    always_comb begin
        up        = target > duty;
        diff      = up ? target - duty : duty - target;
        reached   = (step == '0) || (step >= diff);
        next_duty = reached ? target : (up ? duty + step : duty - step);
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: command-driven duty ramp sequencer for one pwm instance
module pwm_ramp_ctrl import pwm_pkg::*; #(
    parameter int R          = R_DEF,
    parameter int TIMER_BITS = TIMER_BITS_DEF,
    parameter int HOLD_BITS  = HOLD_BITS_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [R-1:0]          cmd_target,
    input  logic [R-1:0]          cmd_step,
    input  logic [HOLD_BITS-1:0]  cmd_hold,
    input  logic [TIMER_BITS-1:0] cmd_period,
    input  logic                  abort,
    output logic [R-1:0]          duty_cycle,
    output logic [TIMER_BITS-1:0] final_value,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    ramp_state_t           state, state_n;
    logic                  rdy_q;
    logic [R-1:0]          duty_n, target_q, target_n, step_q, step_n, next_duty;
    logic [HOLD_BITS-1:0]  hold_q, hold_n, hold_cnt, hold_cnt_n;
    logic [TIMER_BITS-1:0] final_n;
    logic                  busy_n, done_n, aborted_n, reached;

    // rdy_q keeps cmd_ready low through reset and its first clock out of it
    assign cmd_ready = (state == IDLE) && rdy_q;

    pwm_ramp_step #(.R(R)) u_step (
        .duty      (duty_cycle),
        .target    (target_q),
        .step      (step_q),
        .next_duty (next_duty),
        .reached   (reached)
    );

    // next-state and next-output decode; abort beats a due step
    always_comb begin
        state_n    = state;
        duty_n     = duty_cycle;
        target_n   = target_q;
        step_n     = step_q;
        hold_n     = hold_q;
        hold_cnt_n = hold_cnt;
        final_n    = final_value;
        aborted_n  = 1'b0;
        if (state == IDLE && cmd_valid && cmd_ready) begin
            target_n   = cmd_target;
            step_n     = cmd_step;
            hold_n     = cmd_hold;
            hold_cnt_n = cmd_hold;
            final_n    = cmd_period;
            state_n    = (cmd_target == duty_cycle) ? DONE : RAMP;
        end else if (state == RAMP) begin
            if (abort) begin
                state_n   = IDLE;
                aborted_n = 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt_n = hold_cnt - HOLD_BITS'(1);
            end else begin
                duty_n     = next_duty;
                hold_cnt_n = hold_q;
                state_n    = reached ? DONE : RAMP;
            end
        end else if (state != IDLE) begin
            state_n = IDLE;
        end
        busy_n = state_n != IDLE;
        done_n = state_n == DONE;
    end

    // state and registered outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rdy_q       <= 1'b0;
            duty_cycle  <= '0;
            final_value <= '0;
            target_q    <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            hold_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_n;
            rdy_q       <= 1'b1;
            duty_cycle  <= duty_n;
            final_value <= final_n;
            target_q    <= target_n;
            step_q      <= step_n;
            hold_q      <= hold_n;
            hold_cnt    <= hold_cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            aborted     <= aborted_n;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scenario tasks checked against a per-command duty timeline model
module tb_pwm_ramp_ctrl;
    logic        clk_in = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
    logic [7:0]  cmd_target = '0, cmd_step = '0;
    logic [15:0] cmd_hold = '0;
    logic [14:0] cmd_period = '0;
    logic        cmd_ready, busy, done, aborted;
    logic [7:0]  duty_cycle;
    logic [14:0] final_value;
    int          pass_cnt = 0, total_cnt = 0;
    logic [7:0]  m_duty = '0;

    always #5 clk_in = ~clk_in;

    pwm_ramp_ctrl dut (
        .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
        .cmd_period(cmd_period), .abort(abort), .duty_cycle(duty_cycle),
        .final_value(final_value), .busy(busy), .done(done), .aborted(aborted)
    );

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [7:0] toward(input logic [7:0] v, input logic [7:0] t, input logic [7:0] s);
        int d;
        d = (t > v) ? int'(t) - int'(v) : int'(v) - int'(t);
        if (s == 0 || int'(s) >= d) return t;
        return (t > v) ? v + s : v - s;
    endfunction

    // Issue one command and follow it to completion; abort_n is the edge offset
    // (after the accept edge) at which abort is sampled, or -1 for none.
    task automatic do_cmd(input logic [7:0] t, input logic [7:0] s, input int h, input logic [14:0] p,
                          input int abort_n, input bit keep, input logic [7:0] nt, input logic [7:0] ns,
                          input int nh, input logic [14:0] np, input string nm);
        logic [7:0] v, e_duty;
        logic [7:0] dq[$];
        int last;
        bit ab, eb, ed, ea;
        v = m_duty; ab = 0; last = 0;
        dq.push_back(v);
        if (t != v) begin
            for (int n = 1; n < 50000; n++) begin
                if (n == abort_n) begin ab = 1; dq.push_back(v); last = n; break; end
                if (n % (h + 1) == 0) v = toward(v, t, s);
                dq.push_back(v);
                if (v == t) begin last = n; break; end
            end
        end
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL %s ready_before_cmd got %b want 1", nm, cmd_ready);
        else pass_cnt++;
        cmd_target = t; cmd_step = s; cmd_hold = 16'(h); cmd_period = p; cmd_valid = 1'b1;
        tick();
        if (keep) begin
            cmd_target = nt; cmd_step = ns; cmd_hold = 16'(nh); cmd_period = np;
        end else cmd_valid = 1'b0;
        for (int n = 0; n <= last + 1; n++) begin
            eb = (n < last) || (n == last && !ab);
            ed = (n == last) && !ab;
            ea = (n == last) && ab;
            e_duty = dq[(n > last) ? last : n];
            total_cnt++;
            if (duty_cycle !== e_duty) $display("FAIL %s duty n=%0d got %0d want %0d", nm, n, duty_cycle, e_duty);
            else pass_cnt++;
            total_cnt++;
            if (final_value !== p) $display("FAIL %s final_value n=%0d got %0d want %0d", nm, n, final_value, p);
            else pass_cnt++;
            total_cnt++;
            if (busy !== eb) $display("FAIL %s busy n=%0d got %b want %b", nm, n, busy, eb);
            else pass_cnt++;
            total_cnt++;
            if (done !== ed) $display("FAIL %s done n=%0d got %b want %b", nm, n, done, ed);
            else pass_cnt++;
            total_cnt++;
            if (aborted !== ea) $display("FAIL %s aborted n=%0d got %b want %b", nm, n, aborted, ea);
            else pass_cnt++;
            total_cnt++;
            if (cmd_ready !== !eb) $display("FAIL %s cmd_ready n=%0d got %b want %b", nm, n, cmd_ready, !eb);
            else pass_cnt++;
            if (n <= last) begin
                abort = (n + 1 == abort_n);
                tick();
            end
        end
        abort = 1'b0;
        m_duty = v;
    endtask

    task automatic test_reset;
        tick(); tick();
        total_cnt++;
        if ({duty_cycle, final_value, busy, done, aborted, cmd_ready} !== '0)
            $display("FAIL reset_hold got duty=%0d fv=%0d b=%b d=%b a=%b r=%b want all 0",
                     duty_cycle, final_value, busy, done, aborted, cmd_ready);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready);
        else pass_cnt++;
        cmd_target = 8'd100; cmd_step = 8'd40; cmd_hold = 16'd0; cmd_period = 15'd77; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        total_cnt++;
        if (duty_cycle !== 8'd40) $display("FAIL reset_pre_duty got %0d want 40", duty_cycle);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({duty_cycle, final_value, busy, done, aborted, cmd_ready} !== '0)
            $display("FAIL reset_async got duty=%0d fv=%0d b=%b d=%b a=%b r=%b want all 0",
                     duty_cycle, final_value, busy, done, aborted, cmd_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, aborted, busy} !== 3'b000) $display("FAIL reset_no_pulse got d=%b a=%b b=%b want 000", done, aborted, busy);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (cmd_ready !== 1'b1 || duty_cycle !== 8'd0)
            $display("FAIL reset_recover got r=%b duty=%0d want r=1 duty=0", cmd_ready, duty_cycle);
        else pass_cnt++;
        m_duty = '0;
    endtask

    task automatic test_up_ramp;
        do_cmd(8'd10, 8'd3, 2, 15'd100, -1, 0, 0, 0, 0, 0, "up_ramp");
    endtask

    task automatic test_down_ramp;
        do_cmd(8'd250, 8'd0, 0, 15'd300, -1, 0, 0, 0, 0, 0, "down_setup");
        do_cmd(8'd5, 8'd100, 0, 15'd301, -1, 0, 0, 0, 0, 0, "down_sat");
    endtask

    task automatic test_null_step0;
        do_cmd(8'd5, 8'd7, 3, 15'd12, -1, 0, 0, 0, 0, 0, "null_cmd");
        do_cmd(8'd200, 8'd0, 3, 15'd13, -1, 0, 0, 0, 0, 0, "step_zero");
    endtask

    task automatic test_abort;
        do_cmd(8'd0, 8'd0, 0, 15'd1, -1, 0, 0, 0, 0, 0, "abort_setup");
        do_cmd(8'd200, 8'd10, 4, 15'd123, 20, 0, 0, 0, 0, 0, "abort_ramp");
        total_cnt++;
        if (m_duty !== 8'd30 || duty_cycle !== 8'd30) $display("FAIL abort_freeze got %0d want 30", duty_cycle);
        else pass_cnt++;
        do_cmd(8'd60, 8'd10, 1, 15'd124, -1, 0, 0, 0, 0, 0, "after_abort");
    endtask

    task automatic test_back_to_back;
        do_cmd(8'd90, 8'd20, 1, 15'd50, -1, 1, 8'd40, 8'd25, 0, 15'd60, "b2b_first");
        do_cmd(8'd40, 8'd25, 0, 15'd60, -1, 0, 0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] t, s;
            int h, an;
            t = 8'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            h = $urandom_range(0, 3);
            an = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1;
            do_cmd(t, s, h, 15'($urandom), an, 0, 0, 0, 0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_ramp();
        test_null_step0();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
